// File: rtl/sr_latch_pulse_driver_if.sv
// Request/drive bundle between control logic, the pulse driver and the NAND SR latch.
interface sr_latch_pulse_driver_if;
    logic set_req;
    logic clr_req;
    logic ready;
    logic s_n;
    logic r_n;
    logic q_model;
    logic err_both;

    modport master (
        output set_req,
        output clr_req,
        input  ready,
        input  s_n,
        input  r_n,
        input  q_model,
        input  err_both
    );

    modport slave (
        input  set_req,
        input  clr_req,
        output ready,
        output s_n,
        output r_n,
        output q_model,
        output err_both
    );
endinterface

// File: rtl/sr_latch_pulse_driver.sv
// Issues timed active-low set/reset pulses to a cross-coupled NAND SR latch.
// Each pulse is followed by a guard gap with both inputs high. s_n and r_n
// are never low together. The block tracks the expected latch state and
// flags conflicting set/clear requests.
module sr_latch_pulse_driver #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sr_latch_pulse_driver_if.slave   drv
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] LP_PULSE_LD = 8'(PULSE_W - 1);
    localparam logic [7:0] LP_GAP_LD   = 8'(GAP_W - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_s_n;
    logic       w_s_n_nxt;
    logic       r_r_n;
    logic       w_r_n_nxt;
    logic       r_q_model;
    logic       w_q_model_nxt;
    logic       r_err_both;
    logic       w_err_both_nxt;

    // Next-state and next-output logic; only one latch input is ever pulled low.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_s_n_nxt      = r_s_n;
        w_r_n_nxt      = r_r_n;
        w_q_model_nxt  = r_q_model;
        w_err_both_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (drv.set_req && !drv.clr_req) begin
                    w_state_nxt   = PULSE;
                    w_s_n_nxt     = 1'b0;
                    w_r_n_nxt     = 1'b1;
                    w_q_model_nxt = 1'b1;
                    w_cnt_nxt     = LP_PULSE_LD;
                end else if (drv.clr_req && !drv.set_req) begin
                    w_state_nxt   = PULSE;
                    w_s_n_nxt     = 1'b1;
                    w_r_n_nxt     = 1'b0;
                    w_q_model_nxt = 1'b0;
                    w_cnt_nxt     = LP_PULSE_LD;
                end else if (drv.set_req && drv.clr_req) begin
                    w_err_both_nxt = 1'b1;
                end
            end

            PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = GAP;
                    w_s_n_nxt   = 1'b1;
                    w_r_n_nxt   = 1'b1;
                    w_cnt_nxt   = LP_GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            GAP: begin
                w_s_n_nxt = 1'b1;
                w_r_n_nxt = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_s_n_nxt   = 1'b1;
                w_r_n_nxt   = 1'b1;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset releases the latch inputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_s_n      <= 1'b1;
            r_r_n      <= 1'b1;
            r_q_model  <= 1'b0;
            r_err_both <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_s_n      <= w_s_n_nxt;
            r_r_n      <= w_r_n_nxt;
            r_q_model  <= w_q_model_nxt;
            r_err_both <= w_err_both_nxt;
        end
    end

    assign drv.ready    = (r_state == IDLE);
    assign drv.s_n      = r_s_n;
    assign drv.r_n      = r_r_n;
    assign drv.q_model  = r_q_model;
    assign drv.err_both = r_err_both;

endmodule
